fp_square: RTL and testbench



---
 rtl/fp_pkg.sv | 56 +++++
 rtl/fp_square_if.sv | 13 +
 rtl/fp_square_shift_add_mul24.sv | 59 +++++
 rtl/fp_square.sv | 144 ++++++++++++++
 tb/tb_fp_square.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared constants, field slices, state and operand-class encodings for the fp squarer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int EXP_MAX    = 255;
  localparam int MUL_CYCLES = 24;

  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [31:0] POS_INF = 32'h7f800000;

  // IEEE-754 single field positions
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  // Zero and denormals share a class: denormal inputs are flushed to zero.
  function automatic cls_t classify(input logic [7:0] e, input logic [22:0] f);
    cls_t c;
    c = CLS_NORM;
    if (e == 8'd0) begin
      c = CLS_ZERO;
    end else if (e == 8'(EXP_MAX)) begin
      c = (f == 23'd0) ? CLS_INF : CLS_NAN;
    end
    return c;
  endfunction

  // Result sign is always cleared: a square is never negative.
  function automatic logic [31:0] pack_pos(input logic [7:0] e, input logic [22:0] f);
    logic [31:0] w;
    w = 32'd0;
    w[SIGN_BIT]        = 1'b0;
    w[EXP_HI:EXP_LO]   = e;
    w[FRAC_HI:FRAC_LO] = f;
    return w;
  endfunction

endpackage

// File: rtl/fp_square_if.sv
// Start/result handshake bundle between a requester and the fp squarer.
// Latency: n/a (wires only).
// Backpressure: none; start is ignored while busy, never queued.
interface fp_square_if;
  logic [31:0] A;
  logic        start;
  logic [31:0] Out;
  logic        done;
  logic        busy;

  modport master (output A, start, input Out, done, busy);
  modport slave  (input A, start, output Out, done, busy);
endinterface

// File: rtl/fp_square_shift_add_mul24.sv
// 24x24 unsigned shift-add multiplier, one multiplier bit per step, LSB first.
// Latency: 24 step cycles after load; product valid the cycle after done_mul.
// Backpressure: none; caller owns sequencing via load/step.
module shift_add_mul24
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic [47:0] product,
  output logic        done_mul
);

  logic [47:0] acc_q, acc_d;
  logic [47:0] mcand_sh_q, mcand_sh_d;
  logic [23:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;

  // Load clears the accumulator; each step adds the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d      = acc_q;
    mcand_sh_d = mcand_sh_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    if (load) begin
      acc_d      = 48'd0;
      mcand_sh_d = {24'd0, mcand};
      mplier_d   = mplier;
      cnt_d      = 5'd0;
    end else if (step) begin
      acc_d      = acc_q + (mplier_q[0] ? mcand_sh_q : 48'd0);
      mcand_sh_d = mcand_sh_q << 1;
      mplier_d   = mplier_q >> 1;
      cnt_d      = cnt_q + 5'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= 48'd0;
      mcand_sh_q <= 48'd0;
      mplier_q   <= 24'd0;
      cnt_q      <= 5'd0;
    end else begin
      acc_q      <= acc_d;
      mcand_sh_q <= mcand_sh_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
    end
  end

  assign product  = acc_q;
  assign done_mul = step && (cnt_q == 5'(MUL_CYCLES - 1));

endmodule

// File: rtl/fp_square.sv
// IEEE-754 single squarer Out = A*A, shift-add mantissa product, round-to-nearest-even, no denormals.
// Latency: fixed 26 cycles from the start edge to the done pulse, specials included.
// Backpressure: start honoured only in IDLE; starts while busy are dropped.
module fp_square
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fp_square_if.slave  bus
);

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] res_q, res_d;
  logic [31:0] out_q, out_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [7:0]  a_exp;
  logic [22:0] a_frac;
  logic [23:0] a_mant;
  logic        unused_sign;

  logic        mul_load, mul_step, done_mul;
  logic [47:0] prod;

  assign a_exp       = bus.A[EXP_HI:EXP_LO];
  assign a_frac      = bus.A[FRAC_HI:FRAC_LO];
  assign a_mant      = {1'b1, a_frac};
  // The operand sign never affects a square.
  assign unused_sign = bus.A[SIGN_BIT];

  assign mul_load = (state_q == IDLE) && bus.start;
  assign mul_step = (state_q == MUL);

  shift_add_mul24 u_mul (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load),
    .step     (mul_step),
    .mcand    (a_mant),
    .mplier   (a_mant),
    .product  (prod),
    .done_mul (done_mul)
  );

  logic               norm_n;
  logic [22:0]        frac_t;
  logic               guard, sticky, rnd_inc;
  logic [23:0]        frac_r;
  logic               rnd_carry;
  logic signed [9:0]  exp_s;
  logic [31:0]        packed_res;

  // Normalise the 48-bit product, round to nearest even, then resolve specials and range limits.
  always_comb begin
    norm_n    = prod[47];
    frac_t    = norm_n ? prod[46:24] : prod[45:23];
    guard     = norm_n ? prod[23]    : prod[22];
    sticky    = norm_n ? (|prod[22:0]) : (|prod[21:0]);
    rnd_inc   = guard && (sticky || frac_t[0]);
    frac_r    = {1'b0, frac_t} + {23'd0, rnd_inc};
    rnd_carry = frac_r[23];
    exp_s     = $signed({1'b0, exp_q, 1'b0}) - $signed(10'(FP_BIAS))
              + $signed({9'd0, norm_n}) + $signed({9'd0, rnd_carry});
    packed_res = 32'd0;
    case (cls_q)
      CLS_ZERO: packed_res = 32'd0;
      CLS_INF:  packed_res = POS_INF;
      CLS_NAN:  packed_res = QNAN;
      default: begin
        if (exp_s >= $signed(10'(EXP_MAX))) begin
          packed_res = POS_INF;
        end else if (exp_s <= 10'sd0) begin
          packed_res = 32'd0;
        end else begin
          packed_res = pack_pos(exp_s[7:0], rnd_carry ? 23'd0 : frac_r[22:0]);
        end
      end
    endcase
  end

  // Control FSM: capture in IDLE, multiply for 24 cycles, round, then publish with a done pulse.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    exp_d   = exp_q;
    res_d   = res_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cls_d   = classify(a_exp, a_frac);
          exp_d   = a_exp;
          state_d = MUL;
        end
      end
      MUL: begin
        if (done_mul) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        res_d   = packed_res;
        state_d = DONE;
      end
      DONE: begin
        out_d   = res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cls_q   <= CLS_ZERO;
      exp_q   <= 8'd0;
      res_q   <= 32'd0;
      out_q   <= 32'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Out  = out_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fp_square.sv
// Scoreboard bench for fp_square: directed operands with hand-computed squares.
// Latency: checks a fixed 26-cycle start-to-done distance and busy span.
// Backpressure: exercises ignored starts while busy and reset aborting an operation.
module tb_fp_square;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   busy_run;

  typedef struct {
    logic [31:0] val;
    int          acc;
  } exp_t;

  exp_t sb[$];

  fp_square_if sq_if ();

  fp_square dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sq_if)
  );

  localparam int NVEC = 13;
  localparam logic [31:0] VEC_A [0:NVEC-1] = '{
    32'h40400000, 32'h41200000, 32'hc0000000, 32'h3f800000,
    32'h3f800001, 32'h3fffffff, 32'h00000000, 32'h00000001,
    32'h7f7fffff, 32'h1f800000, 32'hff800000, 32'h7fa00000,
    32'h40400000
  };
  localparam logic [31:0] VEC_E [0:NVEC-1] = '{
    32'h41100000, 32'h42c80000, 32'h40800000, 32'h3f800000,
    32'h3f800002, 32'h407ffffe, 32'h00000000, 32'h00000000,
    32'h7f800000, 32'h00000000, 32'h7f800000, 32'h7fc00000,
    32'h41100000
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (reset) busy_run = 0;
    else if (sq_if.busy === 1'b1) busy_run++;
    else busy_run = 0;
    if (!reset && sq_if.done !== 1'b0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=%b with nothing pending, Out=%h", sq_if.done, sq_if.Out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", sq_if.Out, e.val);
        check("latency", 32'(cyc - e.acc), 32'd26);
        check("busy_len", 32'(busy_run), 32'd27);
      end
    end
  end

  task automatic pulse_start(input logic [31:0] a);
    @(negedge clk);
    sq_if.A     = a;
    sq_if.start = 1'b1;
    @(negedge clk);
    sq_if.start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] e);
    exp_t x;
    @(negedge clk);
    sq_if.A     = a;
    sq_if.start = 1'b1;
    x.val = e;
    x.acc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    sq_if.start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    busy_run    = 0;
    reset       = 1'b1;
    sq_if.A     = 32'd0;
    sq_if.start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", sq_if.Out, 32'h0);
    check("reset_done", {31'd0, sq_if.done}, 32'd0);
    check("reset_busy", {31'd0, sq_if.busy}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      issue(VEC_A[i], VEC_E[i]);
      wait_idle();
    end

    // Start at cycle 5 of a 3.0 operation with A=9.0 must be dropped.
    issue(32'h40400000, 32'h41100000);
    repeat (4) @(negedge clk);
    pulse_start(32'h41100000);
    wait_idle();
    repeat (30) @(negedge clk);

    // Reset at cycle 12 aborts; no done may follow.
    pulse_start(32'h40400000);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out", sq_if.Out, 32'h0);
    check("abort_busy", {31'd0, sq_if.busy}, 32'd0);
    check("abort_done", {31'd0, sq_if.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_busy", {31'd0, sq_if.busy}, 32'd0);

    issue(32'h40000000, 32'h40800000);
    wait_idle();
    check("final_busy", {31'd0, sq_if.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
